// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_DEP  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_ORA  = 4'h5;
    localparam logic [3:0] OP_EOR  = 4'h6;
    localparam logic [3:0] OP_LDA  = 4'h7;
    localparam logic [3:0] OP_EXT  = 4'h8;
    localparam logic [3:0] OP_BSW  = 4'h9;
    localparam logic [3:0] OP_LSR  = 4'hA;
    localparam logic [3:0] OP_ASL  = 4'hB;
    localparam logic [3:0] OP_MULU = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_LDF  = 4'hE;
    localparam logic [3:0] OP_STF  = 4'hF;

    localparam int F_C  = 0;
    localparam int F_V  = 1;
    localparam int F_Z  = 2;
    localparam int F_N  = 3;
    localparam int F_A  = 4;
    localparam int F_DZ = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] nxt_lo,
    output logic [WIDTH-1:0] nxt_hi
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dv;
    logic             div_mode;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    always_comb begin
        mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? dv : '0)};
        sh      = {hi, lo[WIDTH-1]};
        diff    = sh - {1'b0, dv};
        ge      = ~diff[WIDTH];
        if (div_mode) begin
            nxt_hi = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // the final step's result is taken combinationally on the done edge
    assign done = run & (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            dv       <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            hi       <= '0;
            lo       <= a;
            dv       <= b;
            div_mode <= is_div;
            cnt      <= '0;
        end else if (run) begin
            hi       <= nxt_hi;
            lo       <= nxt_lo;
            cnt      <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus iterative MULU/DIVU with flush.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FLAGS_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         op,
    input  logic               carry_mask,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [FLAGS_W-1:0] sf_in,
    input  logic               flush,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res_lo,
    output logic [WIDTH-1:0]   res_hi,
    output logic [FLAGS_W-1:0] res_sf,
    output logic               busy
);

    localparam int SW = (WIDTH < 16) ? WIDTH : 16;

    state_t state;

    logic hs;
    logic cin;
    logic md_start;
    logic md_run;
    logic md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [FLAGS_W-1:0] md_sf;

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic [WIDTH:0] sum_inc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [FLAGS_W-1:0] sf;
    logic c, v, acq, dz, shf;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state == S_MUL) | (state == S_DIV);
    assign hs        = req_valid & req_ready;
    assign cin       = sf_in[F_C] & carry_mask;
    assign md_start  = hs & ((op == OP_MULU) | ((op == OP_DIVU) & (|b)));
    assign md_run    = busy & ~flush;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op == OP_DIVU),
        .run    (md_run),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .nxt_lo (md_lo),
        .nxt_hi (md_hi)
    );

    always_comb begin
        md_sf        = '0;
        md_sf[F_C]   = (state == S_MUL) & (|md_hi);
        md_sf[F_Z]   = ~|md_lo;
        md_sf[F_N]   = md_lo[WIDTH-1];
    end

    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~cin};
        sum_inc = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
        lo  = '0;
        hi  = '0;
        c   = sf_in[F_C];
        v   = sf_in[F_V];
        acq = 1'b0;
        dz  = 1'b0;
        shf = 1'b0;
        case (op)
            OP_ADD: begin
                lo = sum_add[WIDTH-1:0];
                c  = sum_add[WIDTH];
                v  = (a[WIDTH-1] == b[WIDTH-1]) & (lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                lo = sum_inc[WIDTH-1:0];
                c  = sum_inc[WIDTH];
            end
            OP_SUB: begin
                lo = sum_sub[WIDTH-1:0];
                c  = sum_sub[WIDTH];
                v  = (a[WIDTH-1] != b[WIDTH-1]) & (lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DEP: begin
                lo  = (|b) ? b - 1'b1 : '0;
                acq = ~|b;
            end
            OP_AND: lo = a & b;
            OP_ORA: lo = a | b;
            OP_EOR: lo = a ^ b;
            OP_LDA: lo = b;
            OP_EXT: lo = {{(WIDTH-8){b[7]}}, b[7:0]};
            OP_BSW: begin
                lo = b;
                lo[SW-1:0] = {b[SW/2-1:0], b[SW-1:SW/2]};
            end
            OP_LSR: begin
                lo  = {cin, a[WIDTH-1:1]};
                c   = a[0];
                shf = 1'b1;
            end
            OP_ASL: begin
                lo  = {a[WIDTH-2:0], cin};
                c   = a[WIDTH-1];
                shf = 1'b1;
            end
            OP_MULU: lo = '0;
            // only the divide-by-zero case completes here
            OP_DIVU: begin
                lo = '1;
                hi = a;
                c  = 1'b0;
                v  = 1'b1;
                dz = 1'b1;
            end
            OP_LDF: lo = WIDTH'(sf_in);
            OP_STF: lo = a;
            default: lo = '0;
        endcase
        sf       = '0;
        sf[F_C]  = c;
        sf[F_V]  = v;
        sf[F_Z]  = ~|lo;
        sf[F_N]  = lo[WIDTH-1] & ~shf;
        sf[F_A]  = acq;
        sf[F_DZ] = dz;
        if (op == OP_LDF) sf = sf_in;
        else if (op == OP_STF) sf = FLAGS_W'(a);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            res_sf    <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        state <= (op == OP_DIVU) ? S_DIV : S_MUL;
                    end else if (hs) begin
                        res_valid <= 1'b1;
                        res_lo    <= lo;
                        res_hi    <= hi;
                        res_sf    <= sf;
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (md_done) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b1;
                        res_lo    <= md_lo;
                        res_hi    <= md_hi;
                        res_sf    <= md_sf;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, corner sequences, random ops.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  op = 4'h0;
    logic        carry_mask = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] sf_in = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic [15:0] res_sf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16), .FLAGS_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .carry_mask (carry_mask),
        .a          (a),
        .b          (b),
        .sf_in      (sf_in),
        .flush      (flush),
        .res_valid  (res_valid),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .res_sf     (res_sf),
        .busy       (busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic        cm;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sf;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] rsf;
        int          edges;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the op definitions, using integer math.
    function automatic vec_t model(input logic [3:0] o, input logic cm,
                                   input logic [15:0] xa, input logic [15:0] xb,
                                   input logic [15:0] xs);
        vec_t r;
        int ua, ub, ci, s, sv, sa, sb;
        longint p;
        logic c, v, acq, dz, nok, raw;
        ua = int'(xa);
        ub = int'(xb);
        sa = $signed(xa);
        sb = $signed(xb);
        ci = (xs[0] & cm) ? 1 : 0;
        r.op = o; r.cm = cm; r.a = xa; r.b = xb; r.sf = xs;
        r.lo = '0; r.hi = '0; r.edges = 0;
        c = xs[0]; v = xs[1]; acq = 0; dz = 0; nok = 1; raw = 0;
        s = 0;
        case (o)
            4'h0: begin
                s = ua + ub + ci; r.lo = s[15:0]; c = (s > 65535);
                sv = sa + sb + ci; v = (sv > 32767) || (sv < -32768);
            end
            4'h1: begin s = ub + 1; r.lo = s[15:0]; c = (s > 65535); end
            4'h2: begin
                s = ua + (65535 - ub) + (1 - ci); r.lo = s[15:0]; c = (s > 65535);
                sv = sa - sb - ci; v = (sv > 32767) || (sv < -32768);
            end
            4'h3: begin r.lo = (ub != 0) ? 16'(ub - 1) : 16'h0; acq = (ub == 0); end
            4'h4: r.lo = xa & xb;
            4'h5: r.lo = xa | xb;
            4'h6: r.lo = xa ^ xb;
            4'h7: r.lo = xb;
            4'h8: r.lo = 16'($signed(xb[7:0]));
            4'h9: r.lo = {xb[7:0], xb[15:8]};
            4'hA: begin r.lo = 16'((ua >> 1) + ci * 32768); c = xa[0]; nok = 0; end
            4'hB: begin r.lo = 16'(((ua * 2) % 65536) + ci); c = xa[15]; nok = 0; end
            4'hC: begin
                p = longint'(ua) * longint'(ub);
                r.lo = p[15:0]; r.hi = p[31:16];
                c = (r.hi != 0); v = 0; r.edges = 16;
            end
            4'hD: begin
                if (ub == 0) begin
                    r.lo = 16'hFFFF; r.hi = xa; c = 0; v = 1; dz = 1;
                end else begin
                    r.lo = 16'(ua / ub); r.hi = 16'(ua % ub);
                    c = 0; v = 0; r.edges = 16;
                end
            end
            4'hE: begin r.lo = xs; raw = 1; end
            default: begin r.lo = xa; raw = 1; end
        endcase
        r.rsf = '0;
        r.rsf[0] = c;
        r.rsf[1] = v;
        r.rsf[2] = (r.lo == 0);
        r.rsf[3] = r.lo[15] & nok;
        r.rsf[4] = acq;
        r.rsf[5] = dz;
        if (raw) r.rsf = (o == 4'hE) ? xs : xa;
        return r;
    endfunction

    task automatic run_op(input string nm, input vec_t e);
        int n, bz;
        chk({nm, " ready"}, req_ready, 1'b1);
        op = e.op; carry_mask = e.cm; a = e.a; b = e.b; sf_in = e.sf;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0; bz = 0;
        while (!res_valid && n < 40) begin
            if (busy) bz++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " valid"}, res_valid, 1'b1);
        chk({nm, " edges"}, n, e.edges);
        chk({nm, " lo"}, res_lo, e.lo);
        chk({nm, " hi"}, res_hi, e.hi);
        chk({nm, " sf"}, res_sf, e.rsf);
        if (e.edges != 0) chk({nm, " busycyc"}, bz, e.edges);
        @(posedge clk); #1;
        chk({nm, " pulse"}, res_valid, 1'b0);
        chk({nm, " hold"}, res_lo, e.lo);
    endtask

    initial begin
        tv[0]  = '{4'h0, 0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h000A, 0};
        tv[1]  = '{4'hC, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'h0001, 16};
        tv[2]  = '{4'hD, 0, 16'h0064, 16'h0007, 16'h0000, 16'h000E, 16'h0002, 16'h0000, 16};
        tv[3]  = '{4'hD, 0, 16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 16'h002A, 0};
        tv[4]  = '{4'h1, 0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 0};
        tv[5]  = '{4'h9, 0, 16'h0000, 16'h12AB, 16'h0000, 16'hAB12, 16'h0000, 16'h0008, 0};
        tv[6]  = '{4'h3, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0014, 0};
        tv[7]  = '{4'h3, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0};
        tv[8]  = '{4'h2, 0, 16'h0005, 16'h0003, 16'h0000, 16'h0002, 16'h0000, 16'h0001, 0};
        tv[9]  = '{4'h2, 1, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 0};
        tv[10] = '{4'hA, 1, 16'h0003, 16'h0000, 16'h0001, 16'h8001, 16'h0000, 16'h0001, 0};
        tv[11] = '{4'hE, 0, 16'h0000, 16'h0000, 16'hABCD, 16'hABCD, 16'h0000, 16'hABCD, 0};
        tv[12] = '{4'hF, 0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 0};
        tv[13] = '{4'h8, 0, 16'h0000, 16'h0080, 16'h0000, 16'hFF80, 16'h0000, 16'h0008, 0};

        #12;
        chk("rst valid", res_valid, 1'b0);
        chk("rst lo", res_lo, 16'h0);
        chk("rst sf", res_sf, 16'h0);
        chk("rst busy", busy, 1'b0);
        chk("rst ready", req_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_op($sformatf("tv%0d", i), tv[i]);

        // flush a multiply at iteration 5, then INC right after
        op = 4'hC; a = 16'h1234; b = 16'h5678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        chk("fl busy", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl idle", req_ready, 1'b1);
        chk("fl novalid", res_valid, 1'b0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (res_valid) seen++;
                @(posedge clk); #1;
            end
            chk("fl stale", seen, 0);
        end
        run_op("fl inc", model(4'h1, 0, 16'h0, 16'hFFFF, 16'h0));

        // back-to-back, flush high in idle must not block
        flush = 1'b1;
        op = 4'h6; a = 16'hF0F0; b = 16'h0FF0; sf_in = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("b2b eor v", res_valid, 1'b1);
        chk("b2b eor lo", res_lo, 16'hFF00);
        chk("b2b eor sf", res_sf, 16'h0008);
        op = 4'h9; b = 16'h12AB;
        @(posedge clk); #1;
        chk("b2b bsw v", res_valid, 1'b1);
        chk("b2b bsw lo", res_lo, 16'hAB12);
        op = 4'h3; b = 16'h0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b dep v", res_valid, 1'b1);
        chk("b2b dep lo", res_lo, 16'h0000);
        chk("b2b dep A", res_sf[4], 1'b1);
        @(posedge clk); #1;
        chk("b2b end", res_valid, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  ro;
            logic [15:0] ra, rb, rs;
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
            rs = 16'($urandom);
            run_op($sformatf("rnd%0d op%h", i, ro),
                   model(ro, 1'($urandom), ra, rb, rs));
        end

        // reset during divide iteration 8
        run_op("pre lda", model(4'h7, 0, 16'h0, 16'h5A5A, 16'h0));
        op = 4'hD; a = 16'h0064; b = 16'h0007; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
        chk("mr busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr lo", res_lo, 16'h0);
        chk("mr sf", res_sf, 16'h0);
        chk("mr busy0", busy, 1'b0);
        chk("mr valid", res_valid, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr ready", req_ready, 1'b1);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (res_valid) seen++;
                @(posedge clk); #1;
            end
            chk("mr stale", seen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
